flit_collector: RTL and testbench

- Upstream neighbour of the packet decoder. Accepts a serial 16-bit flit stream with a valid/ready handshake.
- Assembles one packet of head + NUM_BODY body flits + tail into parallel registers, then issues a one-cycle enable to the decoder.
- Holds the assembled flits stable through a guard window so the decoder's multi-cycle sample/decode/drive sequence always sees a coherent packet.
- Drops malformed packets and flags them.

---
 rtl/noc_pkg.sv | 17 +
 rtl/flit_err_counter.sv | 17 +
 rtl/flit_collector.sv | 175 +++++++++++++++++
 tb/tb_flit_collector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, collector state encoding and default flit width.
package noc_pkg;

  localparam int NOC_FLIT_WIDTH = 16;

  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam logic [1:0] FLIT_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BODY  = 3'd1;
  localparam logic [2:0] ST_TAIL  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;

endpackage

// File: rtl/flit_err_counter.sv
// Saturating 8-bit count of dropped flits/packets; cleared only by reset.
module flit_err_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/flit_collector.sv
// Collects head + NUM_BODY bodies + tail into stable parallel outputs for the packet decoder.
// Define FLIT_COLLECTOR_ERR_CNT_EN to enable the saturating error counter on o_err_count.
module flit_collector
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH   = NOC_FLIT_WIDTH,
  parameter int NUM_BODY     = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] i_flit,
  input  logic [1:0]            i_flit_type,
  input  logic                  i_flit_valid,
  output logic                  o_flit_ready,
  output logic [FLIT_WIDTH-1:0] o_head_flit,
  output logic [FLIT_WIDTH-1:0] o_body_flit_1,
  output logic [FLIT_WIDTH-1:0] o_body_flit_2,
  output logic [FLIT_WIDTH-1:0] o_body_flit_3,
  output logic [FLIT_WIDTH-1:0] o_body_flit_4,
  output logic [FLIT_WIDTH-1:0] o_tail_flit,
  output logic                  o_en,
  output logic                  o_err,
  output logic [7:0]            o_err_count
);

  localparam int CNT_W = $clog2(NUM_BODY + 1);
  localparam int IDX_W = (NUM_BODY > 1) ? $clog2(NUM_BODY) : 1;
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] body_cnt, body_cnt_nxt;
  logic [GRD_W-1:0] grd_cnt, grd_cnt_nxt;
  logic             ready_r, en_r, err_r;
  logic             en_nxt, err_nxt;
  logic             head_wr, body_wr, tail_acc;
  logic             xfer;

  logic [FLIT_WIDTH-1:0] work_head;
  logic [FLIT_WIDTH-1:0] work_body [NUM_BODY];
  logic [FLIT_WIDTH-1:0] out_head;
  logic [FLIT_WIDTH-1:0] out_body  [NUM_BODY];
  logic [FLIT_WIDTH-1:0] out_tail;

  assign xfer = i_flit_valid && ready_r;

  always_comb begin
    state_nxt    = state;
    body_cnt_nxt = body_cnt;
    grd_cnt_nxt  = grd_cnt;
    en_nxt       = 1'b0;
    err_nxt      = 1'b0;
    head_wr      = 1'b0;
    body_wr      = 1'b0;
    tail_acc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          if (i_flit_type == FLIT_HEAD) begin
            head_wr      = 1'b1;
            body_cnt_nxt = '0;
            state_nxt    = ST_BODY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (xfer) begin
          case (i_flit_type)
            FLIT_BODY: begin
              body_wr      = 1'b1;
              body_cnt_nxt = body_cnt + 1'b1;
              if (body_cnt_nxt == CNT_W'(NUM_BODY)) state_nxt = ST_TAIL;
            end
            FLIT_HEAD: begin
              err_nxt      = 1'b1;
              head_wr      = 1'b1;
              body_cnt_nxt = '0;
            end
            default: begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          endcase
        end
      end
      ST_TAIL: begin
        if (xfer) begin
          case (i_flit_type)
            FLIT_TAIL: begin
              tail_acc  = 1'b1;
              en_nxt    = 1'b1;
              state_nxt = ST_ISSUE;
            end
            FLIT_HEAD: begin
              err_nxt      = 1'b1;
              head_wr      = 1'b1;
              body_cnt_nxt = '0;
              state_nxt    = ST_BODY;
            end
            default: begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        grd_cnt_nxt = GRD_W'(GUARD_CYCLES - 1);
        state_nxt   = ST_GUARD;
      end
      ST_GUARD: begin
        if (grd_cnt == '0) state_nxt = ST_IDLE;
        else grd_cnt_nxt = grd_cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control and decoder-facing output registers; outputs change only on tail acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      body_cnt <= '0;
      grd_cnt  <= '0;
      ready_r  <= 1'b0;
      en_r     <= 1'b0;
      err_r    <= 1'b0;
      out_head <= '0;
      out_tail <= '0;
      for (int i = 0; i < NUM_BODY; i++) out_body[i] <= '0;
    end else begin
      state    <= state_nxt;
      body_cnt <= body_cnt_nxt;
      grd_cnt  <= grd_cnt_nxt;
      ready_r  <= (state_nxt == ST_IDLE) || (state_nxt == ST_BODY) || (state_nxt == ST_TAIL);
      en_r     <= en_nxt;
      err_r    <= err_nxt;
      if (tail_acc) begin
        out_head <= work_head;
        out_tail <= i_flit;
        for (int i = 0; i < NUM_BODY; i++) out_body[i] <= work_body[i];
      end
    end
  end

  // Working registers hold the packet in flight, so abandoned packets never reach the outputs
  always_ff @(posedge clk) begin
    if (head_wr) work_head <= i_flit;
    if (body_wr) work_body[body_cnt[IDX_W-1:0]] <= i_flit;
  end

  assign o_flit_ready  = ready_r;
  assign o_en          = en_r;
  assign o_err         = err_r;
  assign o_head_flit   = out_head;
  assign o_body_flit_1 = out_body[0];
  assign o_body_flit_2 = out_body[1];
  assign o_body_flit_3 = out_body[2];
  assign o_body_flit_4 = out_body[3];
  assign o_tail_flit   = out_tail;

`ifdef FLIT_COLLECTOR_ERR_CNT_EN
  flit_err_counter u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_r),
    .count (o_err_count)
  );
`else
  assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_flit_collector.sv
// Bench for flit_collector: packet vector table plus scoreboard of expected assembled packets.
module tb_flit_collector;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_flit;
  logic [1:0]  i_flit_type;
  logic        i_flit_valid;
  logic        o_flit_ready;
  logic [15:0] o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3, o_body_flit_4, o_tail_flit;
  logic        o_en, o_err;
  logic [7:0]  o_err_count;

  always #5 clk = ~clk;

  flit_collector #(.FLIT_WIDTH(16), .NUM_BODY(4), .GUARD_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flit        (i_flit),
    .i_flit_type   (i_flit_type),
    .i_flit_valid  (i_flit_valid),
    .o_flit_ready  (o_flit_ready),
    .o_head_flit   (o_head_flit),
    .o_body_flit_1 (o_body_flit_1),
    .o_body_flit_2 (o_body_flit_2),
    .o_body_flit_3 (o_body_flit_3),
    .o_body_flit_4 (o_body_flit_4),
    .o_tail_flit   (o_tail_flit),
    .o_en          (o_en),
    .o_err         (o_err),
    .o_err_count   (o_err_count)
  );

  typedef struct packed {
    logic [15:0]      head;
    logic [3:0][15:0] body;
    logic [15:0]      tail;
    logic             gaps;
    logic             b2b;
  } pkt_t;

  pkt_t sb_q[$];
  pkt_t mon_e;
  pkt_t last_pkt;
  pkt_t vec[5];

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  int err_since_rst = 0;
  logic prev_en = 1'b0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic pkt_t mk(input logic [15:0] h, b1, b2, b3, b4, t, input logic g, bb);
    pkt_t p;
    p.head = h;
    p.body[0] = b1; p.body[1] = b2; p.body[2] = b3; p.body[3] = b4;
    p.tail = t;
    p.gaps = g;
    p.b2b  = bb;
    return p;
  endfunction

  function automatic logic [95:0] pkt_flits(input pkt_t p);
    return {p.head, p.body[0], p.body[1], p.body[2], p.body[3], p.tail};
  endfunction

  function automatic int exp_count();
`ifdef FLIT_COLLECTOR_ERR_CNT_EN
    return (err_since_rst > 255) ? 255 : err_since_rst;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (o_en === 1'b1) begin
      chk("en_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("pkt_data", {o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3,
                         o_body_flit_4, o_tail_flit}, pkt_flits(mon_e));
      end
      chk("en_one_cycle", prev_en, 0);
      chk("en_err_excl", o_err, 0);
    end
    if (o_err === 1'b1) err_seen++;
    prev_en = (o_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] t, output int waits);
    i_flit       = d;
    i_flit_type  = t;
    i_flit_valid = 1'b1;
    waits = 0;
    while (o_flit_ready !== 1'b1 && waits < 40) begin
      tick();
      waits++;
    end
    if (waits >= 40) chk("ready_timeout", o_flit_ready, 1);
    else tick();
    i_flit_valid = 1'b0;
  endtask

  task automatic bad(input logic [15:0] d, input logic [1:0] t);
    int w;
    send(d, t, w);
    err_exp++;
    err_since_rst++;
  endtask

  task automatic send_pkt(input pkt_t p);
    int w;
    sb_q.push_back(p);
    send(p.head, FLIT_HEAD, w);
    if (p.b2b) chk("guard_head_wait", w, 5);
    if (p.gaps) tick();
    for (int k = 0; k < 4; k++) begin
      send(p.body[k], FLIT_BODY, w);
      if (p.gaps) tick();
    end
    send(p.tail, FLIT_TAIL, w);
    chk("en_latency", o_en, 1);
    last_pkt = p;
  endtask

  task automatic count_guard();
    int n;
    n = 0;
    while (o_flit_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("guard_len", n, 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    vec[0] = mk(16'hA000, 16'h1236, 16'h8001, 16'h4003, 16'hC000, 16'hF00F, 1'b0, 1'b0);
    vec[1] = mk(16'hA000, 16'h1236, 16'h8001, 16'h4003, 16'hC000, 16'hF00F, 1'b1, 1'b0);
    vec[2] = mk(16'h5A5A, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hA5A5, 1'b0, 1'b0);
    vec[3] = mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    vec[4] = mk(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h1357, 16'h2468, 1'b1, 1'b1);

    rst_n = 1'b0;
    i_flit = '0;
    i_flit_type = FLIT_HEAD;
    i_flit_valid = 1'b0;
    repeat (3) tick();
    chk("rst_flits", {o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3,
                      o_body_flit_4, o_tail_flit}, 96'd0);
    chk("rst_ready", o_flit_ready, 0);
    chk("rst_en_err", {o_en, o_err}, 2'b00);
    chk("rst_count", o_err_count, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", o_flit_ready, 1);

    // Stray body then reserved flit in IDLE
    bad(16'h0BAD, FLIT_BODY);
    bad(16'h0BAD, FLIT_RSVD);
    repeat (3) tick();
    chk("stray_err_pulses", err_seen, err_exp);
    chk("stray_err_count", o_err_count, exp_count());

    // Vector table: clean, gapped and back-to-back packets
    for (int i = 0; i < 5; i++) begin
      send_pkt(vec[i]);
      if (!(i + 1 < 5 && vec[i + 1].b2b)) count_guard();
    end
    chk("vec_err_pulses", err_seen, err_exp);

    // Early tail after two bodies: dropped, outputs keep the previous packet
    send(16'hBEEF, FLIT_HEAD, w);
    send(16'h1111, FLIT_BODY, w);
    send(16'h2222, FLIT_BODY, w);
    bad(16'h3333, FLIT_TAIL);
    repeat (3) tick();
    chk("early_tail_err", err_seen, err_exp);
    chk("early_tail_hold", {o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3,
                            o_body_flit_4, o_tail_flit}, pkt_flits(last_pkt));
    send_pkt(vec[0]);
    count_guard();

    // Head arriving mid-body restarts the packet
    send(16'h1111, FLIT_HEAD, w);
    send(16'h2222, FLIT_BODY, w);
    err_exp++;
    err_since_rst++;
    send_pkt(mk(16'h3333, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 1'b0, 1'b0));
    count_guard();
    chk("head_restart_err", err_seen, err_exp);

    // Many errors to exercise counter saturation
    for (int k = 0; k < 300; k++) bad(16'(k), FLIT_RSVD);
    repeat (3) tick();
    chk("sat_err_pulses", err_seen, err_exp);
    chk("sat_err_count", o_err_count, exp_count());

    // Reset after three bodies discards the partial packet
    send(16'h7777, FLIT_HEAD, w);
    for (int k = 0; k < 3; k++) send(16'h0100 + 16'(k), FLIT_BODY, w);
    rst_n = 1'b0;
    tick();
    chk("midrst_flits", {o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3,
                         o_body_flit_4, o_tail_flit}, 96'd0);
    chk("midrst_ready", o_flit_ready, 0);
    chk("midrst_en_err", {o_en, o_err}, 2'b00);
    chk("midrst_count", o_err_count, 0);
    rst_n = 1'b1;
    err_since_rst = 0;
    tick();
    chk("midrst_ready_after", o_flit_ready, 1);
    send_pkt(mk(16'h9999, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0FF0, 1'b0, 1'b0));
    count_guard();
    repeat (3) tick();

    chk("final_err_pulses", err_seen, err_exp);
    chk("final_err_count", o_err_count, exp_count());
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
